// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the round-robin UART transmit arbiter.
// FSM encoding, index width helper and default timeouts.
package uart_tx_arbiter_pkg;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  localparam int BUSY_TO_DEF = 8;
  localparam int LOCK_TO_DEF = 50000;

  function automatic int gid_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request
// at or after ptr, wrapping modulo N.
module uart_tx_arbiter_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = gid_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = W'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte streams with
// round-robin arbitration and per-message locking.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int BUSY_TO = BUSY_TO_DEF,
  parameter  int LOCK_TO = LOCK_TO_DEF,
  localparam int GW      = gid_w(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  input  logic               tx_ready,
  output logic [GW-1:0]      grant_id,
  output logic               busy,
  output logic               locked,
  output logic               err_timeout
);

  localparam int BW = $clog2(BUSY_TO + 1);
  localparam int LW = $clog2(LOCK_TO + 1);

  logic [1:0]       state;
  logic [GW-1:0]    rr_ptr;
  logic [GW-1:0]    owner;
  logic [BW-1:0]    bcnt;
  logic [LW-1:0]    lcnt;
  logic [N_REQ-1:0] own_oh;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] gnt;
  logic [GW-1:0]    gidx;
  logic             any;
  logic             bus_to;

  // While locked only the owner may win; tx_ready gates every grant.
  always_comb begin
    own_oh = N_REQ'(1) << owner;
    elig   = '0;
    if (state == S_IDLE && tx_ready)
      elig = locked ? (req_valid & own_oh) : req_valid;
  end

  uart_tx_arbiter_rr_pick #(
    .N (N_REQ),
    .W (GW)
  ) u_rr_pick (
    .req (elig),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (any)
  );

  assign bus_to      = tx_ready && (bcnt == BW'(BUSY_TO - 1));
  assign req_ready   = (!rst && any) ? gnt : '0;
  assign tx_start    = !rst && (state == S_ISSUE);
  assign err_timeout = !rst && (state == S_WAIT_BUSY) && bus_to;
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      locked   <= 1'b0;
      bcnt     <= '0;
      lcnt     <= '0;
      tx_data  <= '0;
      grant_id <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (any) begin
            tx_data  <= req_data[{gidx, 3'b000} +: 8];
            grant_id <= gidx;
            owner    <= gidx;
            locked   <= !req_last[gidx];
            lcnt     <= '0;
            state    <= S_ISSUE;
            if (int'(gidx) == N_REQ - 1) rr_ptr <= '0;
            else rr_ptr <= gidx + GW'(1);
          end else if (locked && !req_valid[owner]) begin
            // An owner that goes quiet too long forfeits the lock.
            if (lcnt == LW'(LOCK_TO - 1)) begin
              locked <= 1'b0;
              lcnt   <= '0;
            end else begin
              lcnt <= lcnt + LW'(1);
            end
          end
        end
        S_ISSUE: begin
          bcnt  <= '0;
          state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (!tx_ready) state <= S_WAIT_DONE;
          else if (bus_to) state <= S_IDLE;
          else bcnt <= bcnt + BW'(1);
        end
        S_WAIT_DONE: begin
          if (tx_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural
// transmitter model and per-requester byte queues.
module tb_uart_tx_arbiter;

  localparam int N       = 4;
  localparam int BUSY_TO = 8;
  localparam int LOCK_TO = 16;
  localparam int FRAME   = 10;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
    logic       lk;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0] req_last;
  logic [N-1:0] req_ready;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic         tx_ready;
  logic [1:0]   grant_id;
  logic         busy;
  logic         locked;
  logic         err_timeout;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   errs_seen = 0;
  int   bcnt = 0;
  logic mute = 0;
  logic can_accept = 1;
  logic [8:0] rq [N][$];
  exp_t sb [$];

  uart_tx_arbiter #(
    .N_REQ   (N),
    .BUSY_TO (BUSY_TO),
    .LOCK_TO (LOCK_TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_ready    (tx_ready),
    .grant_id    (grant_id),
    .busy        (busy),
    .locked      (locked),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial tx_ready = 1'b1;
  always @(posedge clk) begin
    if (tx_start && !mute) bcnt <= FRAME;
    else if (bcnt != 0) bcnt <= bcnt - 1;
    tx_ready <= (bcnt == 0);
  end

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic int idx_of(logic [N-1:0] v);
    int r = 0;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    logic [N-1:0] acc;
    forever begin
      @(posedge clk);
      acc = req_valid & req_ready;
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = rq[i][0][7:0];
          req_last[i]        = rq[i][0][8];
        end else begin
          req_valid[i]       = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
    end
  end

  initial begin
    logic prev_txr;
    logic prev_rdy;
    logic prev_err;
    logic pend;
    int   start_cyc;
    logic [7:0] cur_data;
    logic [1:0] cur_id;
    exp_t e;
    prev_txr = 1; prev_rdy = 0; prev_err = 0; pend = 0;
    start_cyc = 0; cur_data = 0; cur_id = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        can_accept = 1; pend = 0; prev_rdy = 0; prev_err = 0;
        prev_txr = tx_ready;
      end else begin
        if (pend) chk("start_latency", int'(tx_start), 1);
        if (tx_start) begin
          chk("start_after_accept", int'(pend), 1);
          chk("tx_data", int'(tx_data), int'(cur_data));
          chk("grant_id", int'(grant_id), int'(cur_id));
          start_cyc = cyc;
        end
        pend = 0;
        if (err_timeout) begin
          chk("err_delay", cyc - start_cyc, BUSY_TO);
          chk("err_width", int'(prev_err), 0);
          errs_seen++;
          can_accept = 1;
        end
        prev_err = err_timeout;
        if (tx_ready && !prev_txr) can_accept = 1;
        prev_txr = tx_ready;
        if (req_ready != '0) begin
          chk("rdy_onehot", int'($onehot(req_ready)), 1);
          chk("rdy_width", int'(prev_rdy), 0);
          chk("accept_tx_ready", int'(tx_ready), 1);
          chk("accept_gap", int'(can_accept), 1);
          if (sb.size() == 0) begin
            errors++; checks++;
            $display("FAIL unexpected_accept: got %b expected none", req_ready);
          end else begin
            e = sb.pop_front();
            chk("grant_idx", idx_of(req_ready), int'(e.id));
            chk("grant_data", int'(req_data[int'(e.id)*8 +: 8]), int'(e.data));
            chk("locked_at_accept", int'(locked), int'(e.lk));
            cur_data = e.data;
            cur_id   = e.id;
            pend     = 1;
          end
          can_accept = 0;
        end
        prev_rdy = (req_ready != '0);
      end
    end
  end

  task automatic expect_byte(int id, int d, int lk);
    exp_t e;
    e.id = 2'(id); e.data = 8'(d); e.lk = 1'(lk);
    sb.push_back(e);
  endtask

  task automatic push(int id, int d, int last);
    rq[id].push_back({1'(last), 8'(d)});
  endtask

  task automatic drain(string nm, int lim);
    int n = 0;
    while ((sb.size() != 0 || busy || !tx_ready) && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (n >= lim) begin
      errors++; checks++;
      $display("FAIL %s_drain: %0d bytes pending, expected 0", nm, sb.size());
    end
  endtask

  task automatic zero_outputs(string nm);
    chk({nm, "_req_ready"}, int'(req_ready), 0);
    chk({nm, "_tx_start"}, int'(tx_start), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_locked"}, int'(locked), 0);
    chk({nm, "_grant_id"}, int'(grant_id), 0);
    chk({nm, "_tx_data"}, int'(tx_data), 0);
    chk({nm, "_err"}, int'(err_timeout), 0);
  endtask

  initial begin
    int n;
    int cnt;
    rst = 1; req_valid = '0; req_data = '0; req_last = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    zero_outputs("reset");
    rst = 0;

    // fairness: every requester holds two single-byte messages
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 2; k++) push(i, i * 16 + k, 1);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) expect_byte(i, i * 16 + k, 0);
    drain("fair", 400);

    push(0, 8'h55, 1);
    expect_byte(0, 8'h55, 0);
    drain("single", 100);

    // locked message from req1 while req0 and req2 wait
    push(1, 8'h10, 0); push(1, 8'h11, 0); push(1, 8'h12, 1);
    push(0, 8'hE0, 1); push(2, 8'hE2, 1);
    expect_byte(1, 8'h10, 0); expect_byte(1, 8'h11, 1);
    expect_byte(1, 8'h12, 1); expect_byte(2, 8'hE2, 0);
    expect_byte(0, 8'hE0, 0);
    drain("lock", 300);

    mute = 1;
    push(2, 8'h33, 1);
    expect_byte(2, 8'h33, 0);
    n = 0;
    while (errs_seen == 0 && n < 100) begin @(negedge clk); n++; end
    chk("timeout_seen", errs_seen, 1);
    @(negedge clk);
    chk("timeout_idle", int'(busy), 0);
    mute = 0;
    push(3, 8'h44, 1);
    expect_byte(3, 8'h44, 0);
    drain("after_timeout", 100);
    chk("timeout_once", errs_seen, 1);

    push(3, 8'hA0, 0);
    expect_byte(3, 8'hA0, 0);
    n = 0;
    while (rq[3].size() != 0 && n < 100) begin @(negedge clk); n++; end
    push(0, 8'hB0, 1);
    expect_byte(0, 8'hB0, 0);
    n = 0; cnt = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
      if (!busy && locked) cnt++;
    end
    chk("lock_idle_cycles", cnt, LOCK_TO);
    chk("lock_released", int'(locked), 0);
    drain("lock_to", 100);

    push(3, 8'hF0, 0); push(3, 8'hF1, 1);
    expect_byte(3, 8'hF0, 0);
    n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    push(2, 8'hC2, 1);
    expect_byte(2, 8'hC2, 0); expect_byte(3, 8'hF1, 0);
    n = 0;
    while (!(busy && !tx_ready) && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("pre_reset_locked", int'(locked), 1);
    chk("pre_reset_busy", int'(busy), 1);
    rst = 1;
    @(negedge clk);
    zero_outputs("midreset");
    rst = 0;
    drain("midreset", 200);
    chk("final_unlocked", int'(locked), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between N byte-stream requesters, using round-robin arbitration.
- Sits between the requesters and the transmitter's start/data/ready interface.
- Drives a one-cycle start strobe and tracks the transmitter's ready handshake for each byte.
- Supports message locking: a multi-byte message from one requester is never interleaved with bytes from another.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- BUSY_TO, 8, max cycles to wait for tx_ready to drop after tx_start before declaring a fault.
- LOCK_TO, 50000, max idle cycles a lock is held without a new byte from the lock owner.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester byte available.
- req_data  in  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  N_REQ  byte is the final byte of a message (1 = single-byte or end of message).
- req_ready  out  N_REQ  one-hot one-cycle accept pulse; byte consumed when valid&ready.
- tx_data  out  8  byte presented to the transmitter, held stable from accept until the next accept.
- tx_start  out  1  one-cycle start strobe to the transmitter.
- tx_ready  in  1  transmitter idle (registered, lags its internal state by one cycle).
- grant_id  out  $clog2(N_REQ)  index of the requester currently or most recently served.
- busy  out  1  high in any state other than IDLE.
- locked  out  1  a message lock is active.
- err_timeout  out  1  one-cycle pulse when a BUSY_TO fault occurs.

Behaviour:
- All logic is on posedge clk.
- Reset values: all outputs 0; FSM=IDLE; rr_ptr=0; lock cleared; all counters 0.
- Reset has priority over every other event and aborts any state; the byte in flight is abandoned.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE, eligibility: a requester is eligible when tx_ready=1 and its req_valid=1.
  - When locked, only the lock owner is eligible.
  - When unlocked, the first requester with req_valid=1 is chosen, searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
- IDLE, accept (same cycle as selection):
  - req_ready[g]=1; tx_data<=req_data[g]; grant_id<=g; rr_ptr<=(g+1) mod N_REQ.
  - If req_last[g]=0: lock set, owner=g. If req_last[g]=1: lock cleared.
  - Next state is ISSUE.
- IDLE, nothing eligible: stay in IDLE.
- ISSUE: tx_start=1 for exactly this cycle; clear busy counter; next state is WAIT_BUSY.
- WAIT_BUSY:
  - If tx_ready=0, go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches BUSY_TO-1 with tx_ready still 1: err_timeout=1 for one cycle, go to IDLE. The byte is dropped, not retried, and lock state is unchanged.
- WAIT_DONE: if tx_ready=1, go to IDLE; no timeout in this state.
- Latency: accept to tx_start is 1 cycle. Minimum accept-to-accept spacing is one frame plus about 4 cycles.
- Lock timeout:
  - While locked and in IDLE, an idle counter increments each cycle the owner has req_valid=0.
  - It resets on any accept.
  - At LOCK_TO-1 the lock clears and normal round-robin resumes on the next cycle.
- Simultaneous events:
  - If req_valid rises on several requesters in one cycle, exactly one is granted and the others wait.
  - A requester deasserting valid while not granted loses nothing, because no byte was consumed.
  - req_valid from a non-owner during a lock is ignored.
- tx_ready=0 in IDLE (for example, the transmitter is still finishing after reset): no grant is made.
- req_ready is never asserted for more than one requester or for more than one cycle per byte.
- busy = (state != IDLE); locked reflects the lock register.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE/ISSUE/WAIT_BUSY/WAIT_DONE, 2 bits).
  - The grant-index width function.
  - Default BUSY_TO and LOCK_TO values.
- One sub-module, rr_pick: combinational round-robin priority selector over N_REQ, taking req mask and rr_ptr and returning a one-hot grant, an index and "any".
- The FSM, lock logic and counters stay in the top-level module.

Test Plan:
- N_REQ=4, single request: req0 valid, data 0x55, last=1, with a behavioural TX model.
  - req_ready[0] pulses 1 cycle; tx_start 1 cycle later with tx_data=0x55.
  - Next grant only after tx_ready falls then rises.
- Fairness: all 4 requesters hold valid with last=1 continuously → grant order 0,1,2,3,0,1 with no starvation; 8 bytes accepted in that order.
- Lock: req1 sends 0x10,0x11,0x12 (last only on 0x12) while req0 and req2 hold valid.
  - The three req1 bytes go out consecutively and locked=1 throughout.
  - Then req2 is granted (rr_ptr=2), then req0.
- Busy timeout: the TX model keeps tx_ready=1 after tx_start → err_timeout pulses exactly BUSY_TO cycles after tx_start; FSM returns to IDLE; the next request is served.
- Lock timeout (LOCK_TO=16 in the bench): req3 sends 0xA0 with last=0, then drops valid while req0 is valid → req0 is granted only after 16 idle cycles and locked falls.
- Reset mid-frame: rst asserted in WAIT_DONE → next cycle all outputs are 0, state is IDLE and the lock is cleared; after release, the pending req2 is granted once tx_ready=1.
